// File: rtl/mmio_bus_router_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg
//   Shared definitions for the MMIO bus router:
//   - FSM state type
//   - default address map (data memory, LEDs, switches)
//   - one-hot to binary index encoder
// ---------------------------------------------------------------------------
package mmio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
   localparam logic [31:0] DMEM_MASK = 32'hFFFF_FC00;
   localparam logic [31:0] LED_BASE  = 32'h0000_0400;
   localparam logic [31:0] LED_MASK  = 32'hFFFF_FFFC;
   localparam logic [31:0] SW_BASE   = 32'h0000_0404;
   localparam logic [31:0] SW_MASK   = 32'hFFFF_FFFC;

   // Widest slave vector the encoder accepts.
   localparam int unsigned MAX_SLAVES = 32;

   // OR-reduction encoder; the input is expected to be one-hot or zero.
   function automatic int unsigned onehot_to_idx(input logic [MAX_SLAVES-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < MAX_SLAVES; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/mmio_bus_router_if.sv
// ---------------------------------------------------------------------------
// mmio_bus_router_if
//   CPU load/store handshake plus the flat slave-side bus.
//   modport slave  : the router's view (receives CPU requests, drives slaves)
//   modport master : the environment's view (CPU + peripherals)
// ---------------------------------------------------------------------------
interface mmio_bus_router_if #(
   parameter int unsigned NUM_SLAVES = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                           cpu_req;
   logic                           cpu_write;
   logic [ADDR_WIDTH-1:0]          cpu_addr;
   logic [DATA_WIDTH-1:0]          cpu_wdata;
   logic                           cpu_done;
   logic                           cpu_err;
   logic [DATA_WIDTH-1:0]          cpu_rdata;
   logic [NUM_SLAVES-1:0]          slv_sel;
   logic [NUM_SLAVES-1:0]          slv_write_en;
   logic [ADDR_WIDTH-1:0]          slv_addr;
   logic [DATA_WIDTH-1:0]          slv_wdata;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata;
   logic [NUM_SLAVES-1:0]          slv_ack;

   modport slave (
      input  cpu_req, cpu_write, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
      output cpu_done, cpu_err, cpu_rdata, slv_sel, slv_write_en, slv_addr, slv_wdata
   );

   modport master (
      output cpu_req, cpu_write, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
      input  cpu_done, cpu_err, cpu_rdata, slv_sel, slv_write_en, slv_addr, slv_wdata
   );
endinterface

// File: rtl/mmio_bus_router_decode.sv
// ---------------------------------------------------------------------------
// mmio_addr_decode
//   Combinational address decoder.
//   i_addr/i_write : request address and direction
//   o_sel          : one-hot winning slave (lowest matching index)
//   o_idx          : binary index of the winner
//   o_offset       : address offset within the winner's window
//   o_valid        : a slave matched and the access is permitted
// ---------------------------------------------------------------------------
module mmio_addr_decode
   import mmio_pkg::*;
#(
   parameter int unsigned NUM_SLAVES = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {LED_BASE, DMEM_BASE},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {LED_MASK, DMEM_MASK},
   parameter logic [NUM_SLAVES-1:0]            SLAVE_RO   = '0,
   localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_write,
   output logic [NUM_SLAVES-1:0] o_sel,
   output logic [IDX_W-1:0]      o_idx,
   output logic [ADDR_WIDTH-1:0] o_offset,
   output logic                  o_valid
);

   logic [NUM_SLAVES-1:0] w_hit;
   logic [MAX_SLAVES-1:0] w_sel_ext;

   always_comb begin
      w_hit = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         w_hit[i] = (i_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                    == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      // Isolate the lowest set bit: overlapping windows resolve to the lowest index.
      o_sel = w_hit & (~w_hit + 1'b1);

      w_sel_ext = '0;
      w_sel_ext[NUM_SLAVES-1:0] = o_sel;
      o_idx = IDX_W'(onehot_to_idx(w_sel_ext));

      o_offset = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (o_sel[i]) o_offset = i_addr & ~SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      end

      o_valid = (|w_hit) && !(i_write && ((SLAVE_RO & o_sel) != '0));
   end

endmodule

// File: rtl/mmio_bus_router.sv
// ---------------------------------------------------------------------------
// mmio_bus_router
//   Routes CPU loads/stores to one of NUM_SLAVES address windows, returns
//   read data, and reports unmapped/read-only/timeout errors.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mmio_bus_router_if.slave (CPU handshake + slave select/data/ack)
// ---------------------------------------------------------------------------
module mmio_bus_router
   import mmio_pkg::*;
#(
   parameter int unsigned NUM_SLAVES     = 2,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {LED_BASE, DMEM_BASE},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {LED_MASK, DMEM_MASK},
   parameter logic [NUM_SLAVES-1:0]            SLAVE_RO   = '0,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   mmio_bus_router_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_e                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_write;
   logic                  r_err;
   logic [NUM_SLAVES-1:0] r_sel;
   logic [NUM_SLAVES-1:0] r_wen;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [CNT_W-1:0]      r_cnt;

   logic [NUM_SLAVES-1:0] w_dec_sel;
   logic [IDX_W-1:0]      w_dec_idx;
   logic [ADDR_WIDTH-1:0] w_dec_offset;
   logic                  w_dec_valid;
   logic                  w_ack;
   logic [DATA_WIDTH-1:0] w_slv_rdata;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  w_timeout;

   mmio_addr_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_WIDTH (ADDR_WIDTH),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK),
      .SLAVE_RO   (SLAVE_RO)
   ) u_decode (
      .i_addr   (bus.cpu_addr),
      .i_write  (bus.cpu_write),
      .o_sel    (w_dec_sel),
      .o_idx    (w_dec_idx),
      .o_offset (w_dec_offset),
      .o_valid  (w_dec_valid)
   );

   always_comb begin
      w_ack       = bus.slv_ack[r_idx];
      w_slv_rdata = bus.slv_rdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
      w_cnt_next  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
      // Fires on the ACCESS cycle whose count-up reaches TIMEOUT_CYCLES.
      w_timeout   = (TIMEOUT_CYCLES != 0) && (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_sel   <= '0;
         r_wen   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.cpu_req) begin
                  r_addr  <= w_dec_offset;
                  r_wdata <= bus.cpu_wdata;
                  r_write <= bus.cpu_write;
                  r_rdata <= '0;
                  r_cnt   <= '0;
                  if (w_dec_valid) begin
                     r_state <= ST_ACCESS;
                     r_idx   <= w_dec_idx;
                     r_sel   <= w_dec_sel;
                     r_wen   <= w_dec_sel & {NUM_SLAVES{bus.cpu_write}};
                     r_err   <= 1'b0;
                  end else begin
                     r_state <= ST_RESP;
                     r_err   <= 1'b1;
                  end
               end
            end
            ST_ACCESS: begin
               if (w_ack) begin
                  r_state <= ST_RESP;
                  r_rdata <= r_write ? '0 : w_slv_rdata;
                  r_err   <= 1'b0;
                  r_sel   <= '0;
                  r_wen   <= '0;
                  r_cnt   <= '0;
               end else if (w_timeout) begin
                  r_state <= ST_RESP;
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_sel   <= '0;
                  r_wen   <= '0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= w_cnt_next;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_sel   <= '0;
               r_wen   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.cpu_done     = (r_state == ST_RESP);
      bus.cpu_err      = (r_state == ST_RESP) && r_err;
      bus.cpu_rdata    = r_rdata;
      bus.slv_sel      = r_sel;
      bus.slv_write_en = r_wen;
      bus.slv_addr     = r_addr;
      bus.slv_wdata    = r_wdata;
   end

endmodule

// File: tb/tb_mmio_bus_router.sv
// ---------------------------------------------------------------------------
// tb_mmio_bus_router
//   Directed bench for mmio_bus_router with slave 1 (LED window) read-only
//   and a 16-cycle ack timeout.
// ---------------------------------------------------------------------------
module tb_mmio_bus_router;
   import mmio_pkg::*;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   logic saw_wen1;

   mmio_bus_router_if #(.NUM_SLAVES(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mmio_bus_router #(
      .NUM_SLAVES     (2),
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .SLAVE_BASE     ({32'h0000_0400, 32'h0000_0000}),
      .SLAVE_MASK     ({32'hFFFF_FFFC, 32'hFFFF_FC00}),
      .SLAVE_RO       (2'b10),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.slv_write_en[1] === 1'b1) saw_wen1 = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_req   = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.slv_ack   = '0;
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      saw_wen1 = 1'b0;
      rst      = 1'b1;
      idle_inputs();
      bus.slv_rdata = {32'h0000_00A5, 32'h1234_5678};

      // Reset state
      #1;
      chk("rst_done",  64'(bus.cpu_done), 64'd0);
      chk("rst_err",   64'(bus.cpu_err), 64'd0);
      chk("rst_rdata", 64'(bus.cpu_rdata), 64'd0);
      chk("rst_sel",   64'(bus.slv_sel), 64'd0);
      chk("rst_wen",   64'(bus.slv_write_en), 64'd0);
      chk("rst_addr",  64'(bus.slv_addr), 64'd0);
      chk("rst_wdata", 64'(bus.slv_wdata), 64'd0);
      step(); step();
      rst = 1'b0;
      step();

      // 1) Zero-wait store to slave 0
      bus.slv_ack   = 2'b01;
      bus.cpu_req   = 1'b1;
      bus.cpu_write = 1'b1;
      bus.cpu_addr  = 32'h0000_0010;
      bus.cpu_wdata = 32'hDEAD_BEEF;
      chk("st_t0_sel", 64'(bus.slv_sel), 64'd0);
      step(); // T1
      chk("st_t1_sel",   64'(bus.slv_sel), 64'h1);
      chk("st_t1_wen",   64'(bus.slv_write_en), 64'h1);
      chk("st_t1_addr",  64'(bus.slv_addr), 64'h10);
      chk("st_t1_wdata", 64'(bus.slv_wdata), 64'hDEAD_BEEF);
      chk("st_t1_done",  64'(bus.cpu_done), 64'd0);
      step(); // T2
      chk("st_t2_done", 64'(bus.cpu_done), 64'd1);
      chk("st_t2_err",  64'(bus.cpu_err), 64'd0);
      chk("st_t2_sel",  64'(bus.slv_sel), 64'd0);
      chk("st_t2_wen",  64'(bus.slv_write_en), 64'd0);
      idle_inputs();
      step();
      chk("st_t3_done", 64'(bus.cpu_done), 64'd0);

      // 2) Load from slave 1 with three wait states
      bus.cpu_req   = 1'b1;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = 32'h0000_0400;
      for (int i = 1; i <= 3; i++) begin
         step(); // T1..T3
         chk("ld_wait_sel",  64'(bus.slv_sel), 64'h2);
         chk("ld_wait_wen",  64'(bus.slv_write_en), 64'h0);
         chk("ld_wait_done", 64'(bus.cpu_done), 64'd0);
      end
      step(); // T4
      chk("ld_t4_sel",  64'(bus.slv_sel), 64'h2);
      chk("ld_t4_addr", 64'(bus.slv_addr), 64'h0);
      bus.slv_ack = 2'b10;
      step(); // T5
      chk("ld_t5_done",  64'(bus.cpu_done), 64'd1);
      chk("ld_t5_err",   64'(bus.cpu_err), 64'd0);
      chk("ld_t5_rdata", 64'(bus.cpu_rdata), 64'h0000_00A5);
      chk("ld_t5_sel",   64'(bus.slv_sel), 64'd0);
      idle_inputs();
      step();
      chk("ld_hold_done",  64'(bus.cpu_done), 64'd0);
      chk("ld_hold_rdata", 64'(bus.cpu_rdata), 64'h0000_00A5);

      // 3) Unmapped address
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h0000_1000;
      step(); // T1
      chk("um_done",  64'(bus.cpu_done), 64'd1);
      chk("um_err",   64'(bus.cpu_err), 64'd1);
      chk("um_rdata", 64'(bus.cpu_rdata), 64'd0);
      chk("um_sel",   64'(bus.slv_sel), 64'd0);
      idle_inputs();
      step();

      // 4) Store to read-only window, then a load there
      bus.cpu_req   = 1'b1;
      bus.cpu_write = 1'b1;
      bus.cpu_addr  = 32'h0000_0400;
      bus.cpu_wdata = 32'h0000_00FF;
      step(); // T1
      chk("ro_st_done", 64'(bus.cpu_done), 64'd1);
      chk("ro_st_err",  64'(bus.cpu_err), 64'd1);
      chk("ro_st_wen",  64'(bus.slv_write_en), 64'd0);
      chk("ro_st_sel",  64'(bus.slv_sel), 64'd0);
      idle_inputs();
      step();
      bus.slv_ack   = 2'b10;
      bus.cpu_req   = 1'b1;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = 32'h0000_0400;
      step(); // T1
      chk("ro_ld_sel", 64'(bus.slv_sel), 64'h2);
      step(); // T2
      chk("ro_ld_done",  64'(bus.cpu_done), 64'd1);
      chk("ro_ld_err",   64'(bus.cpu_err), 64'd0);
      chk("ro_ld_rdata", 64'(bus.cpu_rdata), 64'h0000_00A5);
      idle_inputs();
      step();

      // 5) Slave 0 never acks; slave 1 acks spuriously throughout
      bus.slv_ack   = 2'b10;
      bus.cpu_req   = 1'b1;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = 32'h0000_0020;
      for (int i = 1; i <= 16; i++) begin
         step(); // T1..T16
         chk("to_sel",  64'(bus.slv_sel), 64'h1);
         chk("to_done", 64'(bus.cpu_done), 64'd0);
      end
      step(); // T17
      chk("to_done_t17", 64'(bus.cpu_done), 64'd1);
      chk("to_err_t17",  64'(bus.cpu_err), 64'd1);
      chk("to_rdata",    64'(bus.cpu_rdata), 64'd0);
      chk("to_sel_t17",  64'(bus.slv_sel), 64'd0);
      idle_inputs();
      step();

      // 6) Reset asserted during ACCESS
      bus.cpu_req   = 1'b1;
      bus.cpu_write = 1'b1;
      bus.cpu_addr  = 32'h0000_0004;
      bus.cpu_wdata = 32'hCAFE_F00D;
      step(); // T1
      chk("ra_sel_pre", 64'(bus.slv_sel), 64'h1);
      chk("ra_wen_pre", 64'(bus.slv_write_en), 64'h1);
      #2 rst = 1'b1;
      #1;
      chk("ra_sel",   64'(bus.slv_sel), 64'd0);
      chk("ra_wen",   64'(bus.slv_write_en), 64'd0);
      chk("ra_done",  64'(bus.cpu_done), 64'd0);
      chk("ra_wdata", 64'(bus.slv_wdata), 64'd0);
      idle_inputs();
      step();
      chk("ra_done_edge", 64'(bus.cpu_done), 64'd0);
      rst = 1'b0;
      step();
      chk("ra_done_post", 64'(bus.cpu_done), 64'd0);
      chk("ra_sel_post",  64'(bus.slv_sel), 64'd0);

      // Back-to-back requests with cpu_req held high (decode errors)
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h0000_1000;
      step();
      chk("bb_done1", 64'(bus.cpu_done), 64'd1);
      step();
      chk("bb_gap",   64'(bus.cpu_done), 64'd0);
      step();
      chk("bb_done2", 64'(bus.cpu_done), 64'd1);
      idle_inputs();
      step();
      chk("bb_after", 64'(bus.cpu_done), 64'd0);

      chk("wen1_never", 64'(saw_wen1), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
